// File: rtl/lsu_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ram_if
//  Description : Request/response bundle between the core load/store path
//                and lsu_ram (reqValid / busy / respValid handshake).
//  Revision    : 1.0  initial release
// ============================================================================
interface lsu_ram_if;
    logic        reqValid;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wbmask;
    logic [31:0] addr;
    logic        busy;
    logic        respValid;
    logic [31:0] rdata;

    modport master (
        output reqValid, wen, wdata, wbmask, addr,
        input  busy, respValid, rdata
    );

    modport slave (
        input  reqValid, wen, wdata, wbmask, addr,
        output busy, respValid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ram
//  Description : Single-port data RAM behind the load/store unit. Serves one
//                request at a time with a configurable fixed latency, does
//                byte-lane alignment for stores and right-justifies load data.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ram #(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  wire logic   clock,
    input  wire logic   reset,
    lsu_ram_if.slave    bus
);

    localparam int          c_idx_bits  = $clog2(MEM_WORDS);
    localparam logic [31:0] c_byte_span = 32'(4 * MEM_WORDS);
    localparam logic [3:0]  c_lat_m1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    logic        r_wen;
    logic [31:0] r_wdata;
    logic [3:0]  r_wbmask;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;

    logic [31:0] mem [MEM_WORDS];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_use_live;
    logic                  w_wen;
    logic [31:0]           w_wdata;
    logic [3:0]            w_wbmask;
    logic [31:0]           w_addr;
    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [c_idx_bits-1:0] w_idx;
    logic [1:0]            w_sh;
    logic [3:0]            w_lane_mask;
    logic [31:0]           w_lane_data;

    // Only WAIT blocks acceptance; a request in the RESP cycle is taken.
    assign w_accept = bus.reqValid && (r_state != WAIT);

    // The edge entering RESP is the commit edge. With LATENCY=1 that is the
    // accept edge itself, so the live request is used instead of the
    // captured copy whenever we are not already waiting.
    assign w_commit   = (w_state_next == RESP);
    assign w_use_live = (r_state != WAIT);
    assign w_wen      = w_use_live ? bus.wen    : r_wen;
    assign w_wdata    = w_use_live ? bus.wdata  : r_wdata;
    assign w_wbmask   = w_use_live ? bus.wbmask : r_wbmask;
    assign w_addr     = w_use_live ? bus.addr   : r_addr;

    // Wrap-around offset; anything at or beyond the array span is out of range.
    assign w_off       = w_addr - BASE_ADDR;
    assign w_in_range  = (w_off < c_byte_span);
    assign w_idx       = w_off[c_idx_bits+1:2];
    assign w_sh        = w_addr[1:0];
    // Mask bits pushed past lane 3 fall off the 4-bit result.
    assign w_lane_mask = w_wbmask << w_sh;
    assign w_lane_data = w_wdata << {w_sh, 3'b000};

    // Next-state and latency counter logic.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_lat_m1;
                    end
                end else begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Snapshot the request at acceptance so later input changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wen    <= 1'b0;
            r_wdata  <= 32'd0;
            r_wbmask <= 4'd0;
            r_addr   <= 32'd0;
        end else if (w_accept) begin
            r_wen    <= bus.wen;
            r_wdata  <= bus.wdata;
            r_wbmask <= bus.wbmask;
            r_addr   <= bus.addr;
        end
    end

    // Byte-masked store commit; reset aborts an in-flight store.
    always_ff @(posedge clock) begin
        if (!reset && w_commit && w_wen && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane_mask[b]) begin
                    mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    // Response data: right-justified load word, zero for stores/out-of-range.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (w_commit) begin
            if (!w_wen && w_in_range) begin
                r_rdata <= mem[w_idx] >> {w_sh, 3'b000};
            end else begin
                r_rdata <= 32'd0;
            end
        end
    end

    assign bus.busy      = (r_state == WAIT);
    assign bus.respValid = (r_state == RESP);
    assign bus.rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ram
//  Description : Scoreboard bench for lsu_ram at LATENCY=2 and LATENCY=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ram;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lsu_ram_if if2();
    lsu_ram_if if3();

    lsu_ram #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (if2.slave)
    );

    lsu_ram #(.MEM_WORDS(4096), .LATENCY(3), .BASE_ADDR(32'h8000_0000)) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (if3.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel == 3) ? if3.busy : if2.busy;
    endfunction

    function automatic logic resp_of(input int sel);
        return (sel == 3) ? if3.respValid : if2.respValid;
    endfunction

    task automatic drive(input int sel, input logic rv, input logic w,
                         input logic [31:0] d, input logic [3:0] m, input logic [31:0] a);
        if (sel == 3) begin
            if3.reqValid = rv; if3.wen = w; if3.wdata = d; if3.wbmask = m; if3.addr = a;
        end else begin
            if2.reqValid = rv; if2.wen = w; if2.wdata = d; if2.wbmask = m; if2.addr = a;
        end
    endtask

    // Issue one request from a negedge, scramble inputs after accept, and
    // verify latency and busy length; data is checked by the monitor.
    task automatic issue(input int sel, input logic w, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] exp, input int lat, input string name);
        int k;
        int nb;
        k = 0;
        while (busy_of(sel) && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) begin
            checks++; errors++;
            $display("FAIL %s_wait_idle: busy stuck after %0d cycles, required idle", name, k);
        end
        drive(sel, 1'b1, w, d, m, a);
        if (sel == 3) q3.push_back(exp); else q2.push_back(exp);
        @(posedge clock);
        #1 drive(sel, 1'b0, ~w, ~d, ~m, a ^ 32'h0000_0004);
        nb = 0;
        k  = 0;
        do begin
            @(negedge clock);
            k++;
            if (busy_of(sel)) nb++;
        end while (!resp_of(sel) && k < 40);
        check({name, "_latency"}, 32'(k), 32'(lat));
        check({name, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
    endtask

    // Scoreboard monitor for the LATENCY=2 instance.
    always @(negedge clock) begin : mon2
        logic [31:0] e;
        if (if2.respValid === 1'b1) begin
            check("dut2_busy_with_resp", {31'd0, if2.busy}, 32'd0);
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2_unexpected_resp: got respValid=1 rdata=%h, required no response", if2.rdata);
            end else begin
                e = q2.pop_front();
                check("dut2_rdata", if2.rdata, e);
            end
        end
    end

    // Scoreboard monitor for the LATENCY=3 instance.
    always @(negedge clock) begin : mon3
        logic [31:0] e;
        if (if3.respValid === 1'b1) begin
            check("dut3_busy_with_resp", {31'd0, if3.busy}, 32'd0);
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut3_unexpected_resp: got respValid=1 rdata=%h, required no response", if3.rdata);
            end else begin
                e = q3.pop_front();
                check("dut3_rdata", if3.rdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset held with a request pending: nothing may be accepted.
        drive(2, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 32'h8000_0010);
        drive(3, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 32'h8000_0010);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_dut2_busy",  {31'd0, if2.busy},      32'd0);
            check("rst_dut2_resp",  {31'd0, if2.respValid}, 32'd0);
            check("rst_dut2_rdata", if2.rdata,              32'd0);
            check("rst_dut3_busy",  {31'd0, if3.busy},      32'd0);
            check("rst_dut3_resp",  {31'd0, if3.respValid}, 32'd0);
            check("rst_dut3_rdata", if3.rdata,              32'd0);
        end
        reset = 1'b0;
        drive(2, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        drive(3, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        repeat (2) @(negedge clock);

        // LATENCY=2: word, byte and half lanes.
        issue(2, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h8000_0010, 32'h0000_0000, 2, "st_word");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0010, 32'hDEAD_BEEF, 2, "ld_word");
        @(negedge clock);
        check("rdata_hold", if2.rdata, 32'hDEAD_BEEF);
        issue(2, 1'b1, 32'h0000_00AA, 4'h1, 32'h8000_0013, 32'h0000_0000, 2, "st_byte3");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0010, 32'hAAAD_BEEF, 2, "ld_after_byte");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0012, 32'h0000_AAAD, 2, "ld_off2");
        issue(2, 1'b1, 32'h0000_0000, 4'hF, 32'h8000_0020, 32'h0000_0000, 2, "st_zero");
        issue(2, 1'b1, 32'h0000_1234, 4'h3, 32'h8000_0023, 32'h0000_0000, 2, "st_half_ovf");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0020, 32'h3400_0000, 2, "ld_half_ovf");

        // Out-of-range accesses, including one that would alias word 0.
        issue(2, 1'b0, 32'h0,         4'h0, 32'h7FFF_FFFC, 32'h0000_0000, 2, "ld_oor_low");
        issue(2, 1'b1, 32'hCAFE_F00D, 4'hF, 32'h8000_0000, 32'h0000_0000, 2, "st_word0");
        issue(2, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h8000_4000, 32'h0000_0000, 2, "st_oor_high");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_4000, 32'h0000_0000, 2, "ld_oor_high");
        issue(2, 1'b1, 32'h0000_ABCD, 4'h3, 32'h8000_0001, 32'h0000_0000, 2, "st_half_mid");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0000, 32'hCAAB_CD0D, 2, "ld_word0");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0002, 32'h0000_CAAB, 2, "ld_word0_off2");

        // Mid-operation reset aborts a store.
        issue(2, 1'b1, 32'h1122_3344, 4'hF, 32'h8000_0040, 32'h0000_0000, 2, "st_pre40");
        issue(2, 1'b0, 32'h0,         4'h0, 32'h8000_0040, 32'h1122_3344, 2, "ld_pre40");
        drive(2, 1'b1, 1'b1, 32'h5566_7788, 4'hF, 32'h8000_0040);
        @(posedge clock);
        #1 drive(2, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        @(negedge clock);
        check("midrst_busy_before", {31'd0, if2.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_busy",  {31'd0, if2.busy},      32'd0);
        check("midrst_resp",  {31'd0, if2.respValid}, 32'd0);
        check("midrst_rdata", if2.rdata,              32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(2, 1'b0, 32'h0, 4'h0, 32'h8000_0040, 32'h1122_3344, 2, "ld_post_rst");

        // LATENCY=3: busy rejection and back-to-back in the respValid cycle.
        issue(3, 1'b1, 32'h0BAD_CAFE, 4'hF, 32'h8000_0010, 32'h0000_0000, 3, "l3_st");
        q3.push_back(32'h0BAD_CAFE);
        drive(3, 1'b1, 1'b0, 32'd0, 4'h0, 32'h8000_0010);
        @(posedge clock);
        #1 drive(3, 1'b1, 1'b1, 32'h0000_0000, 4'hF, 32'h8000_0010);
        @(negedge clock);
        check("l3_rej_busy1", {31'd0, if3.busy}, 32'd1);
        @(negedge clock);
        check("l3_rej_busy2", {31'd0, if3.busy}, 32'd1);
        drive(3, 1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        @(negedge clock);
        check("l3_rej_resp", {31'd0, if3.respValid}, 32'd1);
        issue(3, 1'b0, 32'h0, 4'h0, 32'h8000_0010, 32'h0BAD_CAFE, 3, "l3_b2b_ld");
        issue(3, 1'b1, 32'h0000_0055, 4'h1, 32'h8000_0011, 32'h0000_0000, 3, "l3_st_byte");
        issue(3, 1'b0, 32'h0, 4'h0, 32'h8000_0010, 32'h0BAD_55FE, 3, "l3_ld_byte");

        repeat (5) @(negedge clock);
        check("dut2_queue_empty", 32'(q2.size()), 32'd0);
        check("dut3_queue_empty", 32'(q3.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ram.md
# lsu_ram

Single-port data RAM that sits directly downstream of the core's load/store path. It serves one request at a time over the team's reqValid/busy/respValid handshake. It applies byte-lane alignment and byte-mask writes, and returns load data right-justified so the core can sign/zero-extend from bit 0. Latency is configurable so core stall logic is exercised under multi-cycle memory.

## Interface
- MEM_WORDS, 4096: number of 32-bit words; power of two.
- LATENCY, 2: cycles from accept to respValid; legal range 1..15.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- reqValid  input  1  request present this cycle.
- wen  input  1  1 = store, 0 = load; qualifies reqValid.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- wbmask  input  4  store byte mask, right-justified (0001/0011/1111); 1111 with addr[1:0]=0 for full-word preload.
- addr  input  32  byte address.
- busy  output  1  request in flight; new requests ignored.
- respValid  output  1  one-cycle completion pulse.
- rdata  output  32  load data, right-justified; valid with respValid, held until next response.

## Operation
- Accept: request accepted at a rising edge when reqValid=1, busy=0, reset=0. respValid=1 in the same cycle does not block acceptance; back-to-back requests are allowed.
- At acceptance, capture wen, wdata, wbmask, addr into internal registers. Input changes after acceptance have no effect.
- FSM states:
  - IDLE: busy=0. On accept, go to WAIT with cnt=LATENCY-1. If LATENCY=1, go straight to RESP.
  - WAIT: busy=1. cnt decrements each cycle. When cnt reaches 1 the next state is RESP.
  - RESP: busy=0, respValid=1 for exactly one cycle. Return to IDLE, or re-enter WAIT/RESP if a new request is accepted this cycle.
- Address decode:
  - off = addr - BASE_ADDR, 32-bit wrap-around subtraction.
  - Word index = off[log2(MEM_WORDS)+1:2].
  - In range iff off < 4*MEM_WORDS.
- Commit on the edge that enters RESP:
  - Store: lane mask = (wbmask << addr[1:0]) & 4'hF; mask bits shifted past lane 3 are dropped. Lane data = wdata << (8*addr[1:0]). Only the masked bytes of the addressed word are written.
  - Load: rdata = word >> (8*addr[1:0]), zero-filled in the upper bits.
  - Store response: rdata = 0.
- Out-of-range address: store is dropped, load returns 0. The response is still produced with normal latency.
- Memory array is not cleared by reset. Contents are undefined until written.

## Timing
- Reset values: busy=0, respValid=0, rdata=0, FSM=IDLE, cnt=0.
- reset asserted mid-operation: the in-flight request is aborted, no write is committed, and no respValid is produced. Outputs take their reset values on the next edge.
- Request accepted at edge E0:
  - busy=1 for cycles E0+1 .. E0+LATENCY-1.
  - respValid=1 in cycle E0+LATENCY.
  - LATENCY=1: busy never asserts; respValid in cycle E0+1.
- A load accepted in the same cycle as a store's respValid observes the stored data.
- reqValid while busy=1 is ignored, not queued. The requester must hold or re-assert reqValid.
- Sustained throughput: one request per LATENCY cycles.
- respValid never asserts without a prior accepted request. busy and respValid are never 1 simultaneously.

## Test plan
- Reset/idle: hold reset 3 cycles with reqValid=1 -> busy=0, respValid=0, rdata=0 throughout; no accept until reset deasserts.
- Word store/load, LATENCY=2:
  - Store 32'hDEADBEEF, mask 1111, addr 32'h8000_0010 -> busy high 1 cycle, respValid in cycle +2, rdata=0.
  - Load at the same addr -> rdata=32'hDEADBEEF.
- Byte/half lanes:
  - Store 32'h000000AA, mask 0001, addr 32'h8000_0013 -> only byte 3 written.
  - Load addr 32'h8000_0010 -> 32'hAAADBEEF.
  - Load addr 32'h8000_0012 -> 32'h0000AAAD.
- Mask overflow: store half 32'h00001234, mask 0011, addr 32'h8000_0023 on a zeroed word -> word reads 32'h34000000 (upper lane dropped).
- Back-to-back and busy rejection, LATENCY=3:
  - Pulse reqValid during busy -> ignored.
  - Assert reqValid in the respValid cycle -> accepted; next respValid exactly 3 cycles later.
- Out-of-range and mid-op reset:
  - Load addr 32'h7FFF_FFFC -> rdata=0 with normal latency.
  - Store to addr 32'h8000_0040, assert reset during busy -> no respValid; a later load of 32'h8000_0040 returns the prior contents.
